sha256_msg_sched: RTL

SHA256_MSG_SCHED -- requirements
Module: sha256_msg_sched

---
 rtl/sha256_pkg.sv | 21 ++
 rtl/sha256_w_next.sv | 16 +
 rtl/sha256_msg_sched.sv | 120 ++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, block geometry and the message-schedule sigma functions.
package sha256_pkg;

    typedef logic [31:0] word_t;

    localparam int unsigned BLOCK_BITS  = 512;
    localparam int unsigned BLOCK_WORDS = 16;

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t sigma0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t sigma1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_w_next.sv
// Combinational next schedule word: sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16].
module sha256_w_next
    import sha256_pkg::*;
(
    input  word_t r0,
    input  word_t r1,
    input  word_t r9,
    input  word_t r14,
    output word_t w_next
);

    always_comb begin
        w_next = sigma1(r14) + r9 + sigma0(r1) + r0;
    end

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message scheduler: loads a 512-bit block in IN_W-bit beats, then streams W[0..ROUNDS-1].
// Optional SHA256_MSG_LEN_EN adds the msg_bits accepted-bit counter port.
module sha256_msg_sched
    import sha256_pkg::*;
#(
    parameter int unsigned IN_W   = 8,
    parameter int unsigned ROUNDS = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             in_ready,
    output logic             w_valid,
    output word_t            w_data,
    output logic [5:0]       w_idx,
    input  logic             w_ready,
    output logic             block_done
`ifdef SHA256_MSG_LEN_EN
    ,
    output logic [63:0]      msg_bits
`endif
);

    localparam int unsigned      BEATS     = BLOCK_BITS / IN_W;
    localparam int unsigned      CNT_W     = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [5:0]       LAST_IDX  = 6'(ROUNDS - 1);

    typedef enum logic {LOAD, EXPAND} state_t;

    state_t                             state;
    // Word 0 occupies the MSBs, so the whole file shifts as one 512-bit big-endian vector.
    logic [0:BLOCK_WORDS-1][31:0]       regs;
    logic [CNT_W-1:0]                   beat_cnt;
    word_t                              w_next;
    logic                               beat_hs;
    logic                               word_hs;

    assign beat_hs = (state == LOAD) && in_ready && in_valid;
    assign word_hs = (state == EXPAND) && w_valid && w_ready;
    assign w_data  = regs[0];

    sha256_w_next u_w_next (
        .r0     (regs[0]),
        .r1     (regs[1]),
        .r9     (regs[9]),
        .r14    (regs[14]),
        .w_next (w_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= LOAD;
            regs       <= '0;
            beat_cnt   <= '0;
            w_idx      <= '0;
            in_ready   <= 1'b0;
            w_valid    <= 1'b0;
            block_done <= 1'b0;
        end else begin
            block_done <= 1'b0;
            if (abort) begin
                state    <= LOAD;
                regs     <= '0;
                beat_cnt <= '0;
                w_idx    <= '0;
                in_ready <= 1'b1;
                w_valid  <= 1'b0;
            end else begin
                case (state)
                    LOAD: begin
                        in_ready <= 1'b1;
                        if (beat_hs) begin
                            regs <= (regs << IN_W) | BLOCK_BITS'(in_data);
                            if (beat_cnt == LAST_BEAT) begin
                                beat_cnt <= '0;
                                state    <= EXPAND;
                                in_ready <= 1'b0;
                                w_valid  <= 1'b1;
                            end else begin
                                beat_cnt <= beat_cnt + CNT_W'(1);
                            end
                        end
                    end
                    EXPAND: begin
                        if (word_hs) begin
                            regs <= {regs[1:BLOCK_WORDS-1], w_next};
                            if (w_idx == LAST_IDX) begin
                                w_idx      <= '0;
                                beat_cnt   <= '0;
                                state      <= LOAD;
                                in_ready   <= 1'b1;
                                w_valid    <= 1'b0;
                                block_done <= 1'b1;
                            end else begin
                                w_idx <= w_idx + 6'd1;
                            end
                        end
                    end
                    default: state <= LOAD;
                endcase
            end
        end
    end

`ifdef SHA256_MSG_LEN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msg_bits <= '0;
        end else if (abort) begin
            msg_bits <= '0;
        end else if (beat_hs) begin
            msg_bits <= msg_bits + 64'(IN_W);
        end
    end
`endif

endmodule
